instr_fetch_unit: RTL and testbench

- Front end of the ARM-subset processor. Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO. Presents {instr, instr_pc, pc_plus8} to decode/control; Instr[31:28], [27:26], [25:20] and [15:12] feed the control unit.
- Consumes the control unit's PCSrc plus the datapath branch target to redirect fetch.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] WORD_BYTES    = 32'd4;
    localparam logic [31:0] PC_R15_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush beats push.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, runs the imem req/ack handshake, buffers words.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus8,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] branch_target
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   stale_addr, stale_addr_n;
    logic [31:0]   target_aligned;
    logic [CW-1:0] count;
    logic [CW:0]   occ_after_push;
    logic          empty, full;
    logic          push, pop, redirect;
    fetch_entry_t  head, wr_entry;

    assign target_aligned = branch_target & ~32'h3;
    assign instr_valid    = !empty;
    assign pop            = instr_valid && instr_ready;
    assign redirect       = pop && PCSrc;
    assign wr_entry       = '{instr: imem_rdata, pc: fetch_pc};
    // Occupancy at the next edge if the current ack is pushed alongside any pop.
    assign occ_after_push = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

    assign imem_req  = (state != IDLE);
    assign imem_addr = (state == DRAIN) ? stale_addr : fetch_pc;

    assign instr    = instr_valid ? head.instr : '0;
    assign instr_pc = instr_valid ? head.pc : '0;
    assign pc_plus8 = instr_valid ? head.pc + PC_R15_OFFSET : '0;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // State, PC and stale-address registers; reset overrides ack and redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            stale_addr <= RESET_PC;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            stale_addr <= stale_addr_n;
        end
    end

    // Next-state, PC update and push decision.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        stale_addr_n = stale_addr;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_n = target_aligned;
                    state_n    = REQ;
                end else if (!full || pop) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Response belongs to the old stream: drop it.
                        fetch_pc_n = target_aligned;
                        state_n    = REQ;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_n = fetch_pc + WORD_BYTES;
                        state_n    = (occ_after_push < (CW+1)'(BUF_DEPTH)) ? REQ : IDLE;
                    end
                end else if (redirect) begin
                    // Keep the in-flight request on its old address until acked.
                    stale_addr_n = fetch_pc;
                    fetch_pc_n   = target_aligned;
                    state_n      = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) fetch_pc_n = target_aligned;
                if (imem_ack) state_n = REQ;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, instr_valid, instr_ready, PCSrc;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc_plus8, branch_target;

    logic        imem_req2, instr_valid2;
    logic [31:0] imem_addr2, imem_rdata2, instr2, instr_pc2, pc_plus82;
    logic        ack2 = 1'b1;
    logic        ready2 = 1'b1;
    logic        pcsrc2 = 1'b0;
    logic [31:0] target2 = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_plus8      (pc_plus8),
        .instr_ready   (instr_ready),
        .PCSrc         (PCSrc),
        .branch_target (branch_target)
    );

    assign imem_rdata2 = ~imem_addr2;

    instr_fetch_unit #(
        .RESET_PC  (32'hFFFF_FFF8),
        .BUF_DEPTH (2)
    ) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req2),
        .imem_addr     (imem_addr2),
        .imem_ack      (ack2),
        .imem_rdata    (imem_rdata2),
        .instr_valid   (instr_valid2),
        .instr         (instr2),
        .instr_pc      (instr_pc2),
        .pc_plus8      (pc_plus82),
        .instr_ready   (ready2),
        .PCSrc         (pcsrc2),
        .branch_target (target2)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        pcsrc;
        logic [31:0] target;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_p8;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_instr,
                           input logic [31:0] e_pc, input logic [31:0] e_p8);
        chk({tag, ".req"},   {31'b0, imem_req},    {31'b0, e_req});
        chk({tag, ".addr"},  imem_addr,            e_addr);
        chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, e_valid});
        chk({tag, ".instr"}, instr,                e_instr);
        chk({tag, ".pc"},    instr_pc,             e_pc);
        chk({tag, ".p8"},    pc_plus8,             e_p8);
    endtask

    // Apply inputs for the coming rising edge and advance to the next falling edge.
    task automatic step(input logic ack, input logic [31:0] rd, input logic rdy,
                        input logic src, input logic [31:0] tgt);
        imem_ack      = ack;
        imem_rdata    = rd;
        instr_ready   = rdy;
        PCSrc         = src;
        branch_target = tgt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0; PCSrc = 1'b0; branch_target = '0;

        // Free run: ack every cycle, consumer always ready, then drain to empty.
        vt[0] = '{1'b1, 32'hAAAA_0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'h0,         32'h0, 32'h0};
        vt[1] = '{1'b1, 32'hE3A0_0000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0,         32'h0, 32'h0};
        vt[2] = '{1'b1, 32'hE3A0_1004, 1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b1, 32'hE3A0_0000, 32'h0, 32'h8};
        vt[3] = '{1'b1, 32'hE3A0_2008, 1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'hE3A0_1004, 32'h4, 32'hC};
        vt[4] = '{1'b1, 32'hE3A0_300C, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'hE3A0_2008, 32'h8, 32'h10};
        vt[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'hE3A0_300C, 32'hC, 32'h14};
        vt[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0,         32'h0, 32'h0};
        vt[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0,         32'h0, 32'h0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("run[%0d]", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
                    vt[i].e_instr, vt[i].e_pc, vt[i].e_p8);
            step(vt[i].ack, vt[i].rdata, vt[i].ready, vt[i].pcsrc, vt[i].target);
        end

        // Backpressure: two pushes fill the buffer, request stops, resumes after a pop.
        do_reset();
        step(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
        chk_out("bp.c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 32'hE280_1001, 1'b0, 1'b0, 32'h0);
        chk_out("bp.c2", 1'b1, 32'h4, 1'b1, 32'hE280_1001, 32'h0, 32'h8);
        step(1'b1, 32'hE280_2002, 1'b0, 1'b0, 32'h0);
        chk_out("bp.c3", 1'b0, 32'h8, 1'b1, 32'hE280_1001, 32'h0, 32'h8);
        step(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0);
        chk_out("bp.c4", 1'b0, 32'h8, 1'b1, 32'hE280_1001, 32'h0, 32'h8);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_out("bp.c5", 1'b1, 32'h8, 1'b1, 32'hE280_2002, 32'h4, 32'hC);

        // Redirect while a request waits for a late ack: stale data dropped.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hE280_1001, 1'b0, 1'b0, 32'h0);
        chk_out("dr.c2", 1'b1, 32'h4, 1'b1, 32'hE280_1001, 32'h0, 32'h8);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_out("dr.c3", 1'b1, 32'h4, 1'b1, 32'hE280_1001, 32'h0, 32'h8);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
        chk_out("dr.c4", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_out("dr.c5", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk_out("dr.c6", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 32'hEA00_0100, 1'b0, 1'b0, 32'h0);
        chk_out("dr.c7", 1'b1, 32'h104, 1'b1, 32'hEA00_0100, 32'h100, 32'h108);

        // Redirect in the same cycle as an ack: that word never appears.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hE280_1001, 1'b0, 1'b0, 32'h0);
        chk_out("ra.c2", 1'b1, 32'h4, 1'b1, 32'hE280_1001, 32'h0, 32'h8);
        step(1'b1, 32'hBADB_AD00, 1'b1, 1'b1, 32'h0000_0200);
        chk_out("ra.c3", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 32'hE1A0_0200, 1'b0, 1'b0, 32'h0);
        chk_out("ra.c4", 1'b1, 32'h204, 1'b1, 32'hE1A0_0200, 32'h200, 32'h208);

        // Wrap-around instance free-runs from FFFF_FFF8.
        do_reset();
        chk("wrap.c0.req", {31'b0, imem_req2}, 32'h0);
        chk("wrap.c0.addr", imem_addr2, 32'hFFFF_FFF8);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap.c1.addr", imem_addr2, 32'hFFFF_FFF8);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap.c2.addr", imem_addr2, 32'hFFFF_FFFC);
        chk("wrap.c2.pc", instr_pc2, 32'hFFFF_FFF8);
        chk("wrap.c2.p8", pc_plus82, 32'h0000_0000);
        chk("wrap.c2.instr", instr2, 32'h0000_0007);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap.c3.addr", imem_addr2, 32'h0000_0000);
        chk("wrap.c3.pc", instr_pc2, 32'hFFFF_FFFC);
        chk("wrap.c3.p8", pc_plus82, 32'h0000_0004);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap.c4.addr", imem_addr2, 32'h0000_0004);
        chk("wrap.c4.pc", instr_pc2, 32'h0000_0000);

        // Reset during an outstanding request, with ack and redirect in the same cycle.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hE280_1001, 1'b0, 1'b0, 32'h0);
        chk_out("rm.c2", 1'b1, 32'h4, 1'b1, 32'hE280_1001, 32'h0, 32'h8);
        reset = 1'b1;
        step(1'b1, 32'hBAD0_0003, 1'b1, 1'b1, 32'h0000_0300);
        chk_out("rm.c3", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        step(1'b1, 32'hBAD0_0004, 1'b0, 1'b0, 32'h0);
        chk_out("rm.c4", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 32'hE3A0_5555, 1'b0, 1'b0, 32'h0);
        chk_out("rm.c5", 1'b1, 32'h4, 1'b1, 32'hE3A0_5555, 32'h0, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
